// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit for an RV32I pipeline.
// Drives a single-port data memory over a req/gnt/rvalid handshake,
// formats load data, and stalls the pipeline while an access is in flight.
module mem_stage_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_store_data,
  input  logic [4:0]        in_rd,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic [4:0]        out_rd,
  output logic              out_exc,
  output logic              stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_next;

  // Transaction context latched at accept
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [4:0]  r_rd;
  logic        r_flushed;

  // Registered write-back result
  logic [31:0] r_out_data;
  logic [4:0]  r_out_rd;
  logic        r_out_exc;

  // Decode of the incoming instruction
  logic        w_is_mem;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_exc;
  logic        w_accept;
  logic        w_mem_go;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_wstrb;

  // Load formatting
  logic [31:0] w_shift;
  logic [31:0] w_load;

  assign w_is_mem  = in_mem_read | in_mem_write;
  // Sizes 011/11x do not exist; unsigned sizes make no sense for a store.
  assign w_illegal = w_is_mem &&
                     ((in_funct3 inside {3'b011, 3'b110, 3'b111}) ||
                      (in_mem_write && in_funct3[2]));
  assign w_misaligned = w_is_mem &&
                        (((in_funct3[1:0] == 2'b01) && in_alu_result[0]) ||
                         ((in_funct3[1:0] == 2'b10) && (in_alu_result[1:0] != 2'b00)));
  assign w_exc    = w_illegal | w_misaligned;
  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign w_mem_go = w_accept && w_is_mem && !w_exc;

  // Store lane encoding: data replicated across lanes, strobes pick the bytes
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_st_wdata = in_store_data;
    w_st_wstrb = 4'b0000;
    case (in_funct3[1:0])
      2'b00: begin
        w_st_wdata = {4{in_store_data[7:0]}};
        w_st_wstrb = 4'b0001 << in_alu_result[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{in_store_data[15:0]}};
        w_st_wstrb = 4'b0011 << in_alu_result[1:0];
      end
      2'b10: w_st_wstrb = 4'b1111;
      default: w_st_wstrb = 4'b0000;
    endcase
  end

  // Load lane select and sign/zero extension
  assign w_shift = mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'h0, w_shift[7:0]};
      3'b101:  w_load = {16'h0, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a started handshake always runs to completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_mem_go ? S_REQ : S_DONE;
      S_REQ:  if (mem_gnt) w_next = S_WAIT;
      S_WAIT: if (mem_rvalid) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction context and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_funct3   <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rd       <= '0;
      r_flushed  <= 1'b0;
      r_out_data <= '0;
      r_out_rd   <= '0;
      r_out_exc  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= in_alu_result;
        r_funct3  <= in_funct3;
        r_rd      <= in_rd;
        r_flushed <= 1'b0;
        r_we      <= w_mem_go && in_mem_write;
        r_wdata   <= (w_mem_go && in_mem_write) ? w_st_wdata : 32'h0;
        r_wstrb   <= (w_mem_go && in_mem_write) ? w_st_wstrb : 4'h0;
        // Non-memory and faulting instructions finish without a memory access
        if (!w_mem_go) begin
          r_out_data <= w_is_mem ? 32'h0 : in_alu_result;
          r_out_rd   <= in_rd;
          r_out_exc  <= w_exc;
        end
      end
      if ((r_state == S_REQ || r_state == S_WAIT) && flush) r_flushed <= 1'b1;
      // A flushed access still completes but leaves the visible result untouched
      if (r_state == S_WAIT && mem_rvalid && !r_flushed && !flush) begin
        r_out_data <= r_we ? 32'h0 : w_load;
        r_out_rd   <= r_rd;
        r_out_exc  <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign stall     = !in_ready;
  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = r_we;
  assign mem_addr  = ADDR_W'({r_addr[31:2], 2'b00});
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign out_valid = (r_state == S_DONE) && !r_flushed && !flush;
  assign out_data  = r_out_data;
  assign out_rd    = r_out_rd;
  assign out_exc   = r_out_exc;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu with a
// configurable-latency memory responder.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_alu_result = 32'h0;
  logic [31:0] in_store_data = 32'h0;
  logic [4:0]  in_rd = 5'd0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_exc;
  logic        stall;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_rd(in_rd), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_exc(out_exc), .stall(stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard of expected write-back results
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
    logic        chk_data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every out_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_cycle", cyc, mon_e.cyc);
        check("out_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
        check("out_exc", {31'd0, out_exc}, {31'd0, mon_e.exc});
        if (mon_e.chk_data) check("out_data", out_data, mon_e.data);
      end
    end
  end

  // Memory responder configuration and expectations (written by the main sequence)
  int          gnt_delay = 0;
  int          rv_delay = 0;
  logic [31:0] rdata_cfg = 32'h0;
  logic        force_rv = 1'b0;
  bit          chk_mem = 1'b0;
  bit          chk_wr = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_wdata = 32'h0;
  logic [3:0]  exp_wstrb = 4'h0;

  // Responder state
  int g_wait = 0;
  int rv_wait = 0;
  bit pend_rv = 1'b0;
  bit seen_req = 1'b0;
  int req_cnt = 0;

  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      mem_gnt = 1'b0;
      mem_rvalid = force_rv;
      mem_rdata = rdata_cfg;
      if (!rst_n) begin
        pend_rv = 1'b0;
        seen_req = 1'b0;
      end else if (pend_rv) begin
        if (rv_wait == 0) begin
          mem_rvalid = 1'b1;
          pend_rv = 1'b0;
        end else begin
          rv_wait--;
        end
      end else if (mem_req) begin
        req_cnt++;
        if (!seen_req) begin
          seen_req = 1'b1;
          g_wait = gnt_delay;
        end
        if (chk_mem) begin
          check("mem_addr", mem_addr, exp_addr);
          check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
          if (chk_wr) begin
            check("mem_wdata", mem_wdata, exp_wdata);
            check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
          end
        end
        if (g_wait == 0) begin
          mem_gnt = 1'b1;
          pend_rv = 1'b1;
          seen_req = 1'b0;
          rv_wait = rv_delay;
        end else begin
          g_wait--;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Present one instruction; optionally push its expected result with its latency
  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                       input bit push, input logic [31:0] edata, input logic eexc,
                       input bit echk, input int lat);
    exp_t e;
    int   b;
    b = 0;
    while (!in_ready && b < 100) begin
      tick();
      b++;
    end
    if (!in_ready) check("issue_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_mem_read = rd_op;
    in_mem_write = wr_op;
    in_funct3 = f3;
    in_alu_result = addr;
    in_store_data = sd;
    in_rd = rd;
    if (push) begin
      e.data = edata;
      e.rd = rd;
      e.exc = eexc;
      e.chk_data = echk;
      e.cyc = cyc + lat;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    in_mem_read = 1'b0;
    in_mem_write = 1'b0;
  endtask

  // Wait for the scoreboard to empty and the LSU to return to idle
  task automatic drain(input bit chk_stall);
    int b;
    b = 0;
    while (sb.size() != 0 && b < 60) begin
      if (chk_stall) check("stall_busy", {31'd0, stall}, 32'd1);
      tick();
      b++;
    end
    while ((!in_ready || pend_rv) && b < 60) begin
      tick();
      b++;
    end
    if (b >= 60) check("drain_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic [31:0] edata;
    logic        eexc;
    int          lat;
    int          nreq;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } vec_t;

  vec_t vecs[$];

  int req0;

  initial begin
    // Reset state
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // rd_op wr_op f3 addr sd rdata -> data exc lat nreq mem_addr wdata wstrb
    vecs.push_back('{0, 0, 3'b000, 32'd15,   32'h0,        32'h0,        32'd15,       0, 1, 0, 32'h0,   32'h0,        4'h0});
    vecs.push_back('{1, 0, 3'b000, 32'h103,  32'h0,        32'h80FF7F01, 32'hFFFFFF80, 0, 3, 1, 32'h100, 32'h0,        4'h0});
    vecs.push_back('{1, 0, 3'b100, 32'h103,  32'h0,        32'h80FF7F01, 32'h00000080, 0, 3, 1, 32'h100, 32'h0,        4'h0});
    vecs.push_back('{1, 0, 3'b001, 32'h102,  32'h0,        32'h80FF7F01, 32'hFFFF80FF, 0, 3, 1, 32'h100, 32'h0,        4'h0});
    vecs.push_back('{1, 0, 3'b101, 32'h102,  32'h0,        32'h80FF7F01, 32'h000080FF, 0, 3, 1, 32'h100, 32'h0,        4'h0});
    vecs.push_back('{1, 0, 3'b010, 32'h100,  32'h0,        32'h80FF7F01, 32'h80FF7F01, 0, 3, 1, 32'h100, 32'h0,        4'h0});
    vecs.push_back('{1, 0, 3'b000, 32'h101,  32'h0,        32'h80FF7F01, 32'h0000007F, 0, 3, 1, 32'h100, 32'h0,        4'h0});
    vecs.push_back('{0, 1, 3'b001, 32'h22,   32'h1234ABCD, 32'h0,        32'h0,        0, 3, 1, 32'h20,  32'hABCDABCD, 4'b1100});
    vecs.push_back('{0, 1, 3'b000, 32'h41,   32'h000000EF, 32'h0,        32'h0,        0, 3, 1, 32'h40,  32'hEFEFEFEF, 4'b0010});
    vecs.push_back('{0, 1, 3'b010, 32'h80,   32'hDEADBEEF, 32'h0,        32'h0,        0, 3, 1, 32'h80,  32'hDEADBEEF, 4'b1111});
    vecs.push_back('{1, 0, 3'b010, 32'h6,    32'h0,        32'h0,        32'h0,        1, 1, 0, 32'h0,   32'h0,        4'h0});
    vecs.push_back('{1, 0, 3'b001, 32'h5,    32'h0,        32'h0,        32'h0,        1, 1, 0, 32'h0,   32'h0,        4'h0});
    vecs.push_back('{0, 1, 3'b100, 32'h0,    32'h0,        32'h0,        32'h0,        1, 1, 0, 32'h0,   32'h0,        4'h0});
    vecs.push_back('{1, 0, 3'b011, 32'h0,    32'h0,        32'h0,        32'h0,        1, 1, 0, 32'h0,   32'h0,        4'h0});

    foreach (vecs[i]) begin
      rdata_cfg = vecs[i].rdata;
      chk_mem = 1'b1;
      chk_wr = vecs[i].wr_op;
      exp_addr = vecs[i].maddr;
      exp_we = vecs[i].wr_op;
      exp_wdata = vecs[i].wdata;
      exp_wstrb = vecs[i].wstrb;
      req0 = req_cnt;
      issue(vecs[i].rd_op, vecs[i].wr_op, vecs[i].f3, vecs[i].addr, vecs[i].sd,
            5'(i + 1), 1'b1, vecs[i].edata, vecs[i].eexc, !vecs[i].eexc, vecs[i].lat);
      drain(1'b0);
      check("req_cycles", req_cnt - req0, vecs[i].nreq);
    end

    // Backpressure: grant after 3 cycles, response 2 cycles after grant
    gnt_delay = 3;
    rv_delay = 2;
    rdata_cfg = 32'h11223344;
    exp_addr = 32'h200;
    exp_we = 1'b0;
    chk_wr = 1'b0;
    req0 = req_cnt;
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd20, 1'b1, 32'h11223344, 1'b0, 1'b1, 8);
    drain(1'b1);
    check("bp_req_cycles", req_cnt - req0, 32'd4);
    gnt_delay = 0;

    // Flush while waiting for the response
    rv_delay = 3;
    exp_addr = 32'h300;
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd21, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    tick();
    check("flush_in_wait_req", {31'd0, mem_req}, 32'd0);
    check("flush_in_wait_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(1'b0);
    check("flush_rvalid_consumed", {31'd0, pend_rv}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    rv_delay = 0;
    issue(1'b0, 1'b0, 3'b000, 32'hCAFE, 32'h0, 5'd22, 1'b1, 32'hCAFE, 1'b0, 1'b1, 1);
    drain(1'b0);

    // Reset while the request is outstanding
    chk_mem = 1'b0;
    gnt_delay = 20;
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd23, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    gnt_delay = 0;
    tick();
    rdata_cfg = 32'h55AA55AA;
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    tick();
    tick();
    check("stray_rvalid_in_ready", {31'd0, in_ready}, 32'd1);
    check("stray_rvalid_mem_req", {31'd0, mem_req}, 32'd0);
    issue(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd24, 1'b1, 32'h77, 1'b0, 1'b1, 1);
    drain(1'b0);

    tick();
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
